// File: rtl/gate_truth_checker.sv
// gate_truth_checker: built-in self-test sequencer for a two-input, six-output gate bank.
// Drives every {A,B} vector in turn, holds it for SETTLE_CYCLES, samples the six gate
// outputs for one CHECK cycle and accumulates a sticky per-gate mismatch mask.
// Ports:
//   clk, rst_n       clock, synchronous active-low reset
//   START            level request, only honoured in IDLE
//   AND_IN..XNOR_IN  gate-bank outputs under test
//   A_DRV, B_DRV     stimulus to the gate bank (registered)
//   BUSY, DONE       run in progress / one-cycle end-of-run pulse
//   PASS             1 when all 24 checks matched (valid from DONE to next run)
//   FAIL_MASK        sticky mismatch [0]AND [1]OR [2]XOR [3]NAND [4]NOR [5]XNOR
//   FIRST_FAIL       {A,B} of the first vector showing any mismatch
module gate_truth_checker #(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       START,
  input  logic       AND_IN,
  input  logic       OR_IN,
  input  logic       XOR_IN,
  input  logic       NAND_IN,
  input  logic       NOR_IN,
  input  logic       XNOR_IN,
  output logic       A_DRV,
  output logic       B_DRV,
  output logic       BUSY,
  output logic       DONE,
  output logic       PASS,
  output logic [5:0] FAIL_MASK,
  output logic [1:0] FIRST_FAIL
);

  localparam int unsigned CNT_W = 8;
  localparam int unsigned NGATE = 6;
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_CHECK  = 2'd2,
    S_REPORT = 2'd3
  } state_t;

  state_t           state, state_nxt;
  logic [1:0]       vec, vec_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             a_nxt, b_nxt, busy_nxt, done_nxt, pass_nxt;
  logic [NGATE-1:0] mask_nxt;
  logic [1:0]       first_nxt;

  logic [NGATE-1:0] expected;
  logic [NGATE-1:0] observed;
  logic [NGATE-1:0] mismatch;
  logic [NGATE-1:0] mask_acc;

  // Golden truth table for the vector currently driven
  always_comb begin
    expected = {~(vec[1] ^ vec[0]), ~(vec[1] | vec[0]), ~(vec[1] & vec[0]),
                (vec[1] ^ vec[0]), (vec[1] | vec[0]), (vec[1] & vec[0])};
    observed = {XNOR_IN, NOR_IN, NAND_IN, XOR_IN, OR_IN, AND_IN};
    mismatch = observed ^ expected;
    mask_acc = FAIL_MASK | mismatch;
  end

  // Next-state and next-output logic; every output is registered from these values
  always_comb begin
    state_nxt = state;
    vec_nxt   = vec;
    cnt_nxt   = cnt;
    a_nxt     = A_DRV;
    b_nxt     = B_DRV;
    busy_nxt  = BUSY;
    done_nxt  = 1'b0;
    pass_nxt  = PASS;
    mask_nxt  = FAIL_MASK;
    first_nxt = FIRST_FAIL;

    unique case (state)
      S_IDLE: begin
        a_nxt    = 1'b0;
        b_nxt    = 1'b0;
        busy_nxt = 1'b0;
        if (START) begin
          state_nxt = S_SETTLE;
          vec_nxt   = 2'd0;
          cnt_nxt   = '0;
          busy_nxt  = 1'b1;
          pass_nxt  = 1'b0;
          mask_nxt  = '0;
          first_nxt = 2'd0;
        end
      end

      S_SETTLE: begin
        if (cnt == SETTLE_LAST) begin
          state_nxt = S_CHECK;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end

      S_CHECK: begin
        mask_nxt = mask_acc;
        // Only the first vector that shows any mismatch is recorded
        if ((mismatch != '0) && (FAIL_MASK == '0)) begin
          first_nxt = vec;
        end
        if (vec == 2'd3) begin
          state_nxt = S_REPORT;
          done_nxt  = 1'b1;
          busy_nxt  = 1'b0;
          pass_nxt  = (mask_acc == '0);
          a_nxt     = 1'b0;
          b_nxt     = 1'b0;
        end else begin
          state_nxt = S_SETTLE;
          vec_nxt   = vec + 2'd1;
          cnt_nxt   = '0;
          {a_nxt, b_nxt} = vec + 2'd1;
        end
      end

      S_REPORT: begin
        state_nxt = S_IDLE;
        busy_nxt  = 1'b0;
      end

      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      vec        <= 2'd0;
      cnt        <= '0;
      A_DRV      <= 1'b0;
      B_DRV      <= 1'b0;
      BUSY       <= 1'b0;
      DONE       <= 1'b0;
      PASS       <= 1'b0;
      FAIL_MASK  <= '0;
      FIRST_FAIL <= 2'd0;
    end else begin
      state      <= state_nxt;
      vec        <= vec_nxt;
      cnt        <= cnt_nxt;
      A_DRV      <= a_nxt;
      B_DRV      <= b_nxt;
      BUSY       <= busy_nxt;
      DONE       <= done_nxt;
      PASS       <= pass_nxt;
      FAIL_MASK  <= mask_nxt;
      FIRST_FAIL <= first_nxt;
    end
  end

endmodule
